// File: rtl/mod_round_router_if.sv
// Handshake bundle for mod_round_router: one input stream of round states and
// N_OUT output channels, each with its own valid/ready pair.
interface mod_round_router_if #(
  parameter int N_BYTES = 16,
  parameter int N_OUT   = 2,
  parameter int ADDR_W  = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [ADDR_W-1:0]             in_addr;
  logic [8*N_BYTES-1:0]          in_data;
  logic [N_OUT-1:0]              out_valid;
  logic [N_OUT-1:0]              out_ready;
  logic [N_OUT*8*N_BYTES-1:0]    out_data;
  logic [N_OUT*ADDR_W-1:0]       out_addr;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/mod_round_router.sv
// Routes cipher round states to one of N_OUT single-slot output channels by round index.
// Optional macro ROUND_ROUTER_STATS_EN adds per-channel accept counters and a sticky clamp flag.
module mod_round_router #(
  parameter int N_BYTES  = 16,
  parameter int N_OUT    = 2,
  parameter int ADDR_W   = 4,
  parameter int N_ROUNDS = 14
) (
  input  logic              clk,
  input  logic              rst,
  mod_round_router_if.slave bus,
  output logic              busy
`ifdef ROUND_ROUTER_STATS_EN
  ,
  output logic [N_OUT*16-1:0] cnt,
  output logic                err_addr
`endif
);

  localparam int DATA_W = 8 * N_BYTES;
  localparam int DEST_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [N_OUT-1:0]             slot_valid;
  logic [N_OUT-1:0][DATA_W-1:0] slot_data;
  logic [N_OUT-1:0][ADDR_W-1:0] slot_addr;

  logic [31:0]       addr_ext;
  logic [31:0]       offset;
  logic [DEST_W-1:0] dest;
  logic              accept;

  assign addr_ext = 32'(bus.in_addr);

  // Rounds below N_ROUNDS go to channel 0; later rounds step up one channel each, clamped at the last.
  always_comb begin
    dest   = '0;
    offset = '0;
    if (addr_ext >= 32'(N_ROUNDS)) begin
      offset = addr_ext - 32'(N_ROUNDS) + 32'd1;
      if (offset > 32'(N_OUT - 1)) begin
        dest = DEST_W'(N_OUT - 1);
      end else begin
        dest = DEST_W'(offset);
      end
    end
  end

  assign bus.in_ready = !slot_valid[dest] || bus.out_ready[dest];
  assign accept       = bus.in_valid && bus.in_ready;

  // A load wins over a drain on the same edge, so a full slot can be refilled back-to-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      slot_data  <= '0;
      slot_addr  <= '0;
    end else begin
      for (int c = 0; c < N_OUT; c++) begin
        if (accept && (dest == DEST_W'(c))) begin
          slot_valid[c] <= 1'b1;
          slot_data[c]  <= bus.in_data;
          slot_addr[c]  <= bus.in_addr;
        end else if (slot_valid[c] && bus.out_ready[c]) begin
          slot_valid[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign bus.out_addr  = slot_addr;
  assign busy          = |slot_valid;

`ifdef ROUND_ROUTER_STATS_EN
  logic [N_OUT-1:0][15:0] cnt_r;
  logic                   err_r;

  // Counters wrap naturally at 16 bits; the clamp flag stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (accept) begin
      for (int c = 0; c < N_OUT; c++) begin
        if (dest == DEST_W'(c)) begin
          cnt_r[c] <= cnt_r[c] + 16'd1;
        end
      end
      if (addr_ext > 32'(N_ROUNDS + N_OUT - 2)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign cnt      = cnt_r;
  assign err_addr = err_r;
`endif

endmodule

// File: doc/mod_round_router.md
MOD_ROUND_ROUTER -- requirements
Module: mod_round_router

Interface
REQ-001 SHALL have parameter N_BYTES, default 16, state width in bytes.
REQ-002 SHALL have parameter N_OUT, default 2, output channel count (range 2..8).
REQ-003 SHALL have parameter ADDR_W, default 4, round address width.
REQ-004 SHALL have parameter N_ROUNDS, default 14, first round index routed away from channel 0.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  input state offered.
REQ-008 SHALL have port in_ready  output  1  router accepts the offered state this cycle.
REQ-009 SHALL have port in_addr  input  ADDR_W  round index of the offered state.
REQ-010 SHALL have port in_data  input  8*N_BYTES  state bytes; byte k at bits [8k+7:8k].
REQ-011 SHALL have port out_valid  output  N_OUT  per-channel state held.
REQ-012 SHALL have port out_ready  input  N_OUT  per-channel consumer ready.
REQ-013 SHALL have port out_data  output  N_OUT*8*N_BYTES  per-channel state; channel c in slice c.
REQ-014 SHALL have port out_addr  output  N_OUT*ADDR_W  per-channel round index carried with data.
REQ-015 SHALL have port busy  output  1  OR of out_valid.

Function
REQ-016 SHALL compute dest = 0 when in_addr < N_ROUNDS, else min(in_addr - N_ROUNDS + 1, N_OUT-1).
REQ-017 SHALL hold one registered slot (valid, data, addr) per channel.
REQ-018 SHALL drive in_ready = !out_valid[dest] || out_ready[dest], combinationally from in_addr, slot state and out_ready.
REQ-019 SHALL accept a state when in_valid && in_ready, loading slot dest at that clock edge; out_valid[dest] rises the next cycle (latency 1).
REQ-020 SHALL clear a slot on out_valid[c] && out_ready[c] unless the same edge loads it.
REQ-021 SHALL, on simultaneous drain and load of one slot, keep out_valid[c]=1 and present the new data next cycle, losing no beat.
REQ-022 SHALL hold out_data[c] and out_addr[c] stable while out_valid[c] && !out_ready[c].
REQ-023 SHALL preserve acceptance order per channel and never write a state to more than one channel.
REQ-024 SHALL leave non-destination slots unaffected by an accept.
REQ-025 SHALL let channels drain independently; backpressure on one channel only stalls inputs destined to it.

Reset
REQ-026 SHALL, on rst low, asynchronously clear out_valid, busy, out_data and out_addr to 0 for all channels.
REQ-027 SHALL drop any held states when reset asserts mid-operation; accepting resumes the first clk edge after rst deasserts.
REQ-028 SHALL drive in_ready as defined in REQ-018 (all slots empty, so 1) while rst is low, and accept nothing while rst is low.

Configuration
REQ-029 SHALL support macro ROUND_ROUTER_STATS_EN.
REQ-030 SHALL, with ROUND_ROUTER_STATS_EN defined, add output cnt (N_OUT*16): per-channel accepted-state counters, wrapping at 65535 to 0.
REQ-031 SHALL, with ROUND_ROUTER_STATS_EN defined, add output err_addr (1): sticky, set on an accept with in_addr > N_ROUNDS + N_OUT - 2 (clamped route).
REQ-032 SHALL clear cnt and err_addr only on reset.
REQ-033 SHALL, without ROUND_ROUTER_STATS_EN, omit cnt and err_addr ports and logic, with routing identical in both builds.

Verification
REQ-034 Defaults, out_ready=11, in_addr=3, in_data=0x00..0F -> out_valid=01 next cycle, out_data[0]=0x00..0F, out_addr[0]=3.
REQ-035 Defaults, in_addr=14 then 15, out_ready=11 -> both on channel 1 in order; with STATS_EN err_addr=1 after the addr-15 accept, cnt[1]=2.
REQ-036 Channel 0 full, out_ready=00; in_addr=5 -> in_ready=0; in_addr=14 -> in_ready=1, accepted to channel 1.
REQ-037 Channel 0 full, out_ready[0]=1, in_addr=2 new data -> same-edge drain and load, out_valid[0] stays 1, new data next cycle.
REQ-038 Both slots full, rst low mid-cycle -> out_valid=00, busy=0 immediately; first accept after release lands normally.
REQ-039 Random in_valid/out_ready, 10000 beats, N_OUT=4, N_ROUNDS=10 -> per-channel scoreboard match, no loss or duplication.
